alu_cmd_sequencer: RTL and testbench

- Framed-command controller between the UART core FIFOs and the ALU.
- Pops bytes from the RX FIFO and parses a 5-byte frame: SOF, A, B, OP, CHK.
- Validates the XOR checksum and inter-byte timeout, commits operands to the ALU, samples the result, and pushes a 2-byte response (status, result) into the TX FIFO.
- Replaces free-running operand capture with a protected, sequenced protocol.

---
 rtl/alu_cmd_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Framed command sequencer: RX FIFO -> {SOF,A,B,OP,CHK} -> ALU -> TX FIFO.
// Checksum and inter-byte timeout guard the committed ALU operands.
module alu_cmd_sequencer #(
  parameter int                  BUS_SIZE = 8,
  parameter logic [BUS_SIZE-1:0] SOF_BYTE = 8'hAA,
  parameter int                  TIMEOUT  = 50000,
  parameter int                  TO_BITS  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [BUS_SIZE-1:0] i_rx_data,
  input  logic                i_rx_empty,
  output logic                o_rd_uart,
  output logic [BUS_SIZE-1:0] o_tx_data,
  input  logic                i_tx_full,
  output logic                o_wr_uart,
  output logic [BUS_SIZE-1:0] o_op_a,
  output logic [BUS_SIZE-1:0] o_op_b,
  output logic [BUS_SIZE-3:0] o_op_code,
  input  logic [BUS_SIZE-1:0] i_alu_result,
  output logic                o_busy,
  output logic [7:0]          o_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_GET_OP,
    S_GET_CHK,
    S_EXEC,
    S_SEND_STAT,
    S_SEND_RES
  } state_t;

  localparam logic [TO_BITS-1:0]  TO_LAST  = TO_BITS'(TIMEOUT - 1);
  localparam logic [BUS_SIZE-1:0] ST_OK    = BUS_SIZE'(8'h00);
  localparam logic [BUS_SIZE-1:0] ST_CHK   = BUS_SIZE'(8'h01);
  localparam logic [BUS_SIZE-1:0] ST_TMO   = BUS_SIZE'(8'h02);

  state_t              r_state;
  state_t              w_next;
  logic [BUS_SIZE-1:0] r_sa;
  logic [BUS_SIZE-1:0] r_sb;
  logic [BUS_SIZE-1:0] r_sop;
  logic [BUS_SIZE-1:0] r_op_a;
  logic [BUS_SIZE-1:0] r_op_b;
  logic [BUS_SIZE-3:0] r_op_code;
  logic [BUS_SIZE-1:0] r_status;
  logic [BUS_SIZE-1:0] r_result;
  logic [TO_BITS-1:0]  r_to_cnt;
  logic [7:0]          r_frame_cnt;

  logic                w_rd;
  logic                w_wr;
  logic [BUS_SIZE-1:0] w_txd;
  logic                w_in_get;
  logic                w_to_hit;
  logic                w_chk_ok;

  assign w_in_get = (r_state == S_GET_A) || (r_state == S_GET_B) ||
                    (r_state == S_GET_OP) || (r_state == S_GET_CHK);
  assign w_to_hit = i_rx_empty && (r_to_cnt == TO_LAST);
  assign w_chk_ok = (i_rx_data == (r_sa ^ r_sb ^ r_sop));

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_txd  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (!i_rx_empty) begin
          w_rd = 1'b1;
          if (i_rx_data == SOF_BYTE) w_next = S_GET_A;
        end
      end
      S_GET_A: begin
        if (!i_rx_empty) begin
          w_rd   = 1'b1;
          w_next = S_GET_B;
        end else if (w_to_hit) begin
          w_next = S_SEND_STAT;
        end
      end
      S_GET_B: begin
        if (!i_rx_empty) begin
          w_rd   = 1'b1;
          w_next = S_GET_OP;
        end else if (w_to_hit) begin
          w_next = S_SEND_STAT;
        end
      end
      S_GET_OP: begin
        if (!i_rx_empty) begin
          w_rd   = 1'b1;
          w_next = S_GET_CHK;
        end else if (w_to_hit) begin
          w_next = S_SEND_STAT;
        end
      end
      S_GET_CHK: begin
        if (!i_rx_empty) begin
          w_rd   = 1'b1;
          w_next = w_chk_ok ? S_EXEC : S_SEND_STAT;
        end else if (w_to_hit) begin
          w_next = S_SEND_STAT;
        end
      end
      S_EXEC: w_next = S_SEND_STAT;
      S_SEND_STAT: begin
        if (!i_tx_full) begin
          w_wr   = 1'b1;
          w_txd  = r_status;
          w_next = S_SEND_RES;
        end
      end
      S_SEND_RES: begin
        if (!i_tx_full) begin
          w_wr   = 1'b1;
          w_txd  = r_result;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // FIFO strobes are suppressed while reset is being sampled
    if (!i_reset) begin
      w_rd  = 1'b0;
      w_wr  = 1'b0;
      w_txd = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_sop       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_code   <= '0;
      r_status    <= '0;
      r_result    <= '0;
      r_to_cnt    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd || !w_in_get) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      unique case (r_state)
        S_GET_A, S_GET_B, S_GET_OP: begin
          if (w_rd) begin
            if (r_state == S_GET_A) r_sa <= i_rx_data;
            if (r_state == S_GET_B) r_sb <= i_rx_data;
            if (r_state == S_GET_OP) r_sop <= i_rx_data;
          end else if (w_to_hit) begin
            r_status <= ST_TMO;
            r_result <= '0;
          end
        end
        S_GET_CHK: begin
          if (w_rd) begin
            if (w_chk_ok) begin
              r_op_a    <= r_sa;
              r_op_b    <= r_sb;
              r_op_code <= r_sop[BUS_SIZE-3:0];
            end else begin
              r_status <= ST_CHK;
              r_result <= '0;
            end
          end else if (w_to_hit) begin
            r_status <= ST_TMO;
            r_result <= '0;
          end
        end
        S_EXEC: begin
          r_result    <= i_alu_result;
          r_status    <= ST_OK;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_rd_uart   = w_rd;
  assign o_wr_uart   = w_wr;
  assign o_tx_data   = w_txd;
  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_op_code   = r_op_code;
  assign o_busy      = (r_state != S_IDLE);
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: FIFO models, ALU model, directed table,
// multi-cycle corner sequences and a randomized frame stream.
module tb_alu_cmd_sequencer;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_empty = 1'b1;
  logic       i_tx_full = 1'b0;
  logic       o_rd_uart, o_wr_uart, o_busy;
  logic [7:0] o_tx_data, o_op_a, o_op_b, o_frame_cnt, i_alu_result;
  logic [5:0] o_op_code;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu(o_op_a, o_op_b, o_op_code);

  alu_cmd_sequencer #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty), .o_rd_uart(o_rd_uart),
    .o_tx_data(o_tx_data), .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_op_code(o_op_code),
    .i_alu_result(i_alu_result), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
  );

  typedef struct {
    logic [7:0] d;
    int         gap;
  } rx_t;

  rx_t        rxq[$];
  logic [7:0] txq[$];
  int         txcyc[$];
  int         popcyc[$];
  int         rx_rd = 0, cyc = 0, last_pop = 0, pops = 0;
  int         n_excl = 0, n_bad_rd = 0, n_bad_wr = 0;
  bit         s_rd = 0, full_force = 0, full_rand = 0;
  int         errors = 0, checks = 0;

  // monitor: sample strobes mid-cycle
  always @(negedge clk) begin
    s_rd = o_rd_uart;
    if (o_rd_uart && o_wr_uart) n_excl++;
    if (o_rd_uart && i_rx_empty) n_bad_rd++;
    if (o_wr_uart && i_tx_full) n_bad_wr++;
    if (o_rd_uart) begin
      pops++;
      popcyc.push_back(cyc);
    end
    if (o_wr_uart) begin
      txq.push_back(o_tx_data);
      txcyc.push_back(cyc);
    end
  end

  // FIFO models: a byte becomes visible 'gap' cycles after the previous pop
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (s_rd) begin
      rx_rd    = rx_rd + 1;
      last_pop = cyc - 1;
    end
    if (rx_rd < rxq.size() && cyc >= last_pop + rxq[rx_rd].gap) begin
      i_rx_empty = 1'b0;
      i_rx_data  = rxq[rx_rd].d;
    end else begin
      i_rx_empty = 1'b1;
      i_rx_data  = 8'h00;
    end
    i_tx_full = full_force || (full_rand && $urandom_range(0, 2) == 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d, input int gap);
    rx_t t;
    t.d   = d;
    t.gap = gap;
    rxq.push_back(t);
  endtask

  function automatic logic [7:0] txat(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  function automatic int tcyc(input int i);
    if (i < txcyc.size()) return txcyc[i];
    return -1;
  endfunction

  task automatic wait_tx(input int target, input int budget, input string nm);
    int k = 0;
    while ((txq.size() < target || o_busy) && k < budget) begin
      tick(1);
      k++;
    end
    chk({nm, "_resp_timely"}, 32'(k < budget), 32'd1);
  endtask

  task automatic chk_ops(input string nm, input logic [7:0] a,
                         input logic [7:0] b, input logic [5:0] op,
                         input logic [7:0] cnt);
    chk({nm, "_op_a"}, o_op_a, a);
    chk({nm, "_op_b"}, o_op_b, b);
    chk({nm, "_op_code"}, o_op_code, op);
    chk({nm, "_frame_cnt"}, o_frame_cnt, cnt);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_rd"}, o_rd_uart, 0);
    chk({nm, "_wr"}, o_wr_uart, 0);
    chk({nm, "_tx_data"}, o_tx_data, 0);
    chk_ops(nm, 8'h00, 8'h00, 6'h00, 8'h00);
  endtask

  typedef struct {
    logic [7:0] b[7];
    int         n;
    logic [7:0] st;
    logic [7:0] res;
    logic [7:0] a;
    logic [7:0] bb;
    logic [5:0] op;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[5];

  initial begin
    int base, p0, rel, apop;
    logic [7:0] exq[$];
    logic [7:0] m_a, m_b, m_cnt, g, a, b, op, ck;
    logic [5:0] m_op;

    vt[0] = '{'{8'hAA, 8'h05, 8'h03, 8'h20, 8'h26, 8'h00, 8'h00}, 5,
              8'h00, 8'h08, 8'h05, 8'h03, 6'h20, 8'd1};
    vt[1] = '{'{8'hAA, 8'h05, 8'h03, 8'h20, 8'h27, 8'h00, 8'h00}, 5,
              8'h01, 8'h00, 8'h05, 8'h03, 6'h20, 8'd1};
    vt[2] = '{'{8'h11, 8'h22, 8'hAA, 8'h01, 8'h01, 8'h20, 8'h20}, 7,
              8'h00, 8'h02, 8'h01, 8'h01, 6'h20, 8'd2};
    vt[3] = '{'{8'hAA, 8'h09, 8'h04, 8'hE2, 8'hEF, 8'h00, 8'h00}, 5,
              8'h00, 8'h05, 8'h09, 8'h04, 6'h22, 8'd3};
    vt[4] = '{'{8'hAA, 8'hAA, 8'h0F, 8'h24, 8'h81, 8'h00, 8'h00}, 5,
              8'h00, 8'h0A, 8'hAA, 8'h0F, 6'h24, 8'd4};

    i_reset = 1'b0;
    tick(3);
    chk_reset_outs("reset");
    i_reset = 1'b1;
    tick(1);

    for (int i = 0; i < 5; i++) begin
      base = txq.size();
      p0   = pops;
      for (int j = 0; j < vt[i].n; j++) push(vt[i].b[j], 1);
      wait_tx(base + 2, 300, "vec");
      chk($sformatf("vec%0d_status", i), txat(base), vt[i].st);
      chk($sformatf("vec%0d_result", i), txat(base + 1), vt[i].res);
      chk($sformatf("vec%0d_txcount", i), txq.size() - base, 2);
      chk($sformatf("vec%0d_pops", i), pops - p0, vt[i].n);
      chk_ops($sformatf("vec%0d", i), vt[i].a, vt[i].bb, vt[i].op, vt[i].cnt);
    end

    // inter-byte timeout after A
    base = txq.size();
    p0   = pops;
    push(8'hAA, 1);
    push(8'h05, 1);
    wait_tx(base + 2, TO * 4, "tmo");
    apop = popcyc[popcyc.size() - 1];
    chk("tmo_status", txat(base), 8'h02);
    chk("tmo_result", txat(base + 1), 8'h00);
    chk("tmo_latency", tcyc(base) - apop, TO + 1);
    chk("tmo_pops", pops - p0, 2);
    chk_ops("tmo", 8'hAA, 8'h0F, 6'h24, 8'd4);

    base = txq.size();
    push(8'hAA, 1); push(8'h07, 1); push(8'h02, 1);
    push(8'h20, 1); push(8'h25, 1);
    wait_tx(base + 2, 300, "post_tmo");
    chk("post_tmo_status", txat(base), 8'h00);
    chk("post_tmo_result", txat(base + 1), 8'h09);
    chk_ops("post_tmo", 8'h07, 8'h02, 6'h20, 8'd5);

    // byte lands on the last counter value: accepted
    base = txq.size();
    push(8'hAA, 1); push(8'h05, 1); push(8'h03, TO);
    push(8'h20, 1); push(8'h26, 1);
    wait_tx(base + 2, TO * 4, "edge_byte");
    chk("edge_byte_status", txat(base), 8'h00);
    chk("edge_byte_result", txat(base + 1), 8'h08);
    chk("edge_byte_txcount", txq.size() - base, 2);
    chk_ops("edge_byte", 8'h05, 8'h03, 6'h20, 8'd6);

    // TX back-pressure during the response
    base = txq.size();
    p0   = pops;
    full_force = 1;
    push(8'hAA, 1); push(8'h0C, 1); push(8'h03, 1);
    push(8'h25, 1); push(8'h2A, 1);
    for (int k = 0; k < 100 && pops - p0 < 5; k++) tick(1);
    tick(10);
    chk("full_hold_nopush", txq.size() - base, 0);
    chk("full_hold_busy", o_busy, 1);
    full_force = 0;
    tick(1);
    rel = cyc;
    wait_tx(base + 2, 50, "full");
    chk("full_status", txat(base), 8'h00);
    chk("full_result", txat(base + 1), 8'h0F);
    chk("full_stat_cycle", tcyc(base) - rel, 0);
    chk("full_res_cycle", tcyc(base + 1) - rel, 1);
    chk("full_txcount", txq.size() - base, 2);
    chk_ops("full", 8'h0C, 8'h03, 6'h25, 8'd7);

    // reset while in GET_B with trailing bytes waiting
    p0 = pops;
    push(8'hAA, 1); push(8'h11, 1);
    for (int k = 0; k < 50 && pops - p0 < 2; k++) tick(1);
    tick(2);
    chk("midrst_busy_before", o_busy, 1);
    base = txq.size();
    p0   = pops;
    i_reset = 1'b0;
    push(8'h22, 1); push(8'h33, 1); push(8'h44, 1);
    tick(3);
    chk("midrst_no_pop", pops - p0, 0);
    chk_reset_outs("midrst");
    i_reset = 1'b1;
    push(8'hAA, 1); push(8'h01, 1); push(8'h02, 1);
    push(8'h20, 1); push(8'h23, 1);
    wait_tx(base + 2, 300, "midrst");
    chk("midrst_status", txat(base), 8'h00);
    chk("midrst_result", txat(base + 1), 8'h03);
    chk("midrst_txcount", txq.size() - base, 2);
    chk("midrst_pops", pops - p0, 8);
    chk_ops("midrst", 8'h01, 8'h02, 6'h20, 8'd1);

    // randomized stream against a frame-level reference model
    i_reset = 1'b0;
    tick(2);
    i_reset = 1'b1;
    m_a = 0; m_b = 0; m_op = 0; m_cnt = 0;
    base = txq.size();
    full_rand = 1;
    for (int f = 0; f < 400; f++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        do g = 8'($urandom); while (g == 8'hAA);
        push(g, $urandom_range(1, 3));
      end
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = {2'($urandom), 6'h20 + 6'($urandom_range(0, 8))};
      ck = a ^ b ^ op;
      if ($urandom_range(0, 3) == 0) begin
        ck = ck ^ (8'h01 << $urandom_range(0, 7));
        exq.push_back(8'h01);
        exq.push_back(8'h00);
      end else begin
        exq.push_back(8'h00);
        exq.push_back(alu(a, b, op[5:0]));
        m_a = a; m_b = b; m_op = op[5:0]; m_cnt = m_cnt + 8'd1;
      end
      push(8'hAA, $urandom_range(1, 3));
      push(a, $urandom_range(1, 3));
      push(b, $urandom_range(1, 3));
      push(op, $urandom_range(1, 3));
      push(ck, $urandom_range(1, 3));
    end
    wait_tx(base + exq.size(), 40000, "rand");
    full_rand = 0;
    chk("rand_txcount", txq.size() - base, exq.size());
    for (int i = 0; i < exq.size(); i++)
      chk($sformatf("rand_tx%0d", i), txat(base + i), exq[i]);
    chk_ops("rand", m_a, m_b, m_op, m_cnt);

    chk("rd_wr_exclusive", n_excl, 0);
    chk("rd_only_when_avail", n_bad_rd, 0);
    chk("wr_only_when_space", n_bad_wr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
